// File: rtl/clk_cfg_ctrl_pkg.sv
// Shared types for the I2S clock configuration sequencer: operating parameters, FSM states, legality check.
// CLK_CFG_LOCK_CHECK_EN adds the FAULT state used by the sclk lock-check build.
package clk_cfg_ctrl_pkg;

   typedef enum logic [1:0] {MT = 2'd0, MR = 2'd1, SR = 2'd2, ST = 2'd3} mode_t;
   typedef enum logic [1:0] {k8 = 2'd0, k16 = 2'd1, k32 = 2'd2, k48 = 2'd3} sys_freq_t;
   typedef enum logic [1:0] {hz32 = 2'd0, hz44 = 2'd1, hz48 = 2'd2, hz96 = 2'd3} rate_t;
   typedef enum logic {mono = 1'b0, stereo = 1'b1} chan_t;
   typedef enum logic [1:0] {f16bits = 2'd0, f24bits = 2'd1, f32bits = 2'd2, f_rsvd = 2'd3} frame_t;

   typedef struct packed {
      mode_t     mode;
      sys_freq_t sys_freq;
      rate_t     sample_rate;
      chan_t     chan;
      frame_t    frame;
      logic      mclk_en;
   } OP_t;

   typedef enum logic [2:0] {
      IDLE, DRAIN, HOLD, SETTLE, LOCKED
`ifdef CLK_CFG_LOCK_CHECK_EN
      , FAULT
`endif
   } ccfg_state_t;

   function automatic logic is_master(input OP_t op);
      return (op.mode == MT) || (op.mode == MR);
   endfunction

   // With mclk the divider only supports the 32k system clock at 44.1/48 kHz.
   function automatic logic op_legal(input OP_t op);
      logic legal;
      legal = 1'b0;
      case (op.mode)
         MT, MR: begin
            if (op.mclk_en)
               legal = (op.sys_freq == k32) &&
                       ((op.sample_rate == hz44) || (op.sample_rate == hz48));
            else
               legal = (op.sys_freq == k8) || (op.sys_freq == k16) || (op.sys_freq == k32);
         end
         SR, ST:  legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/sclk_lock_mon.sv
// sclk lock monitor: samples sclk, detects rising edges, counts edges and SETTLE cycles.
// Instantiated only when CLK_CFG_LOCK_CHECK_EN is defined.
module sclk_lock_mon #(
   parameter int LOCK_EDGES  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic pclk,
   input  logic rst,
   input  logic i_run,
   input  logic i_sclk,
   output logic o_lock,
   output logic o_timeout
);

   localparam int EW = $clog2(LOCK_EDGES + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic          r_sclk_q;
   logic [EW-1:0] r_edge_cnt;
   logic [TW-1:0] r_tmr;
   logic          w_rise;

   assign w_rise = i_sclk & ~r_sclk_q;

   // Counters sit at zero outside SETTLE, so every SETTLE entry starts clean.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_sclk_q   <= 1'b0;
         r_edge_cnt <= '0;
         r_tmr      <= '0;
      end else begin
         r_sclk_q <= i_sclk;
         if (!i_run) begin
            r_edge_cnt <= '0;
            r_tmr      <= '0;
         end else begin
            if (w_rise && (r_edge_cnt != EW'(LOCK_EDGES)))
               r_edge_cnt <= r_edge_cnt + 1'b1;
            if (r_tmr != TW'(TIMEOUT_CYC))
               r_tmr <= r_tmr + 1'b1;
         end
      end
   end

   assign o_lock    = i_run && w_rise && (r_edge_cnt == EW'(LOCK_EDGES - 1));
   assign o_timeout = i_run && (r_tmr == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/clk_cfg_ctrl.sv
// Configuration sequencer for the I2S clock divider: validate OP, drain core, reset divider, confirm clocks.
// CLK_CFG_LOCK_CHECK_EN selects sclk-edge lock detection with timeout/FAULT instead of a fixed settle time.
module clk_cfg_ctrl
   import clk_cfg_ctrl_pkg::*;
#(
   parameter int HOLD_CYC    = 4,
   parameter int LOCK_EDGES  = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int SETTLE_CYC  = 256
) (
   input  logic pclk,
   input  logic rst,
   input  logic cfg_valid,
   input  OP_t  cfg_op,
   output logic cfg_ready,
   output logic cfg_err,
   input  logic core_idle,
   input  logic sclk,
   output OP_t  op_out,
   output logic div_rst_,
   output logic xfer_en,
   output logic locked,
   output logic fault
);

`ifdef CLK_CFG_LOCK_CHECK_EN
   localparam int CNT_MAX = HOLD_CYC;
`else
   localparam int CNT_MAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
`endif
   localparam int CW = $clog2(CNT_MAX + 1);

   ccfg_state_t   r_state;
   ccfg_state_t   w_state_next;
   OP_t           r_op;
   OP_t           r_cap;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic          w_ready;
   logic          w_legal;
   logic          w_lock;
   logic          w_timeout;

   assign w_legal = op_legal(cfg_op);

`ifdef CLK_CFG_LOCK_CHECK_EN
   logic [31:0] w_unused_cfg;
   assign w_unused_cfg = 32'(SETTLE_CYC);

   sclk_lock_mon #(
      .LOCK_EDGES (LOCK_EDGES),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_lock_mon (
      .pclk     (pclk),
      .rst      (rst),
      .i_run    (r_state == SETTLE),
      .i_sclk   (sclk),
      .o_lock   (w_lock),
      .o_timeout(w_timeout)
   );
`else
   logic [64:0] w_unused_cfg;
   assign w_unused_cfg = {sclk, 32'(LOCK_EDGES), 32'(TIMEOUT_CYC)};
   assign w_lock    = (r_cnt == CW'(SETTLE_CYC - 1));
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      div_rst_     = 1'b0;
      xfer_en      = 1'b0;
      locked       = 1'b0;
      fault        = 1'b0;
      case (r_state)
         IDLE:   w_ready = 1'b1;
         DRAIN:  if (core_idle) w_state_next = is_master(r_cap) ? HOLD : LOCKED;
         HOLD:   if (r_cnt == CW'(HOLD_CYC - 1)) w_state_next = SETTLE;
         SETTLE: begin
            div_rst_ = 1'b1;
            if (w_lock)
               w_state_next = LOCKED;
`ifdef CLK_CFG_LOCK_CHECK_EN
            else if (w_timeout)
               w_state_next = FAULT;
`endif
         end
         LOCKED: begin
            w_ready  = 1'b1;
            locked   = 1'b1;
            xfer_en  = 1'b1;
            div_rst_ = is_master(r_op);
         end
`ifdef CLK_CFG_LOCK_CHECK_EN
         FAULT: begin
            w_ready = 1'b1;
            fault   = 1'b1;
         end
`endif
         default: w_state_next = IDLE;
      endcase
      if (w_ready && cfg_valid && w_legal)
         w_state_next = DRAIN;
   end

   // r_cnt restarts on every state change; it times both HOLD and the fixed SETTLE.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state <= IDLE;
         r_op    <= '0;
         r_cap   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_err   <= w_ready && cfg_valid && !w_legal;
         if (w_ready && cfg_valid && w_legal)
            r_cap <= cfg_op;
         if ((r_state == DRAIN) && core_idle)
            r_op <= r_cap;
         if (w_state_next != r_state)
            r_cnt <= '0;
         else if (r_cnt != CW'(CNT_MAX))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cfg_ready = w_ready;
   assign cfg_err   = r_err;
   assign op_out    = r_op;

endmodule

// File: tb/tb_clk_cfg_ctrl.sv
// Directed self-checking bench for clk_cfg_ctrl; adapts to CLK_CFG_LOCK_CHECK_EN.
module tb_clk_cfg_ctrl;
   import clk_cfg_ctrl_pkg::*;

   localparam int HOLD_CYC    = 4;
   localparam int LOCK_EDGES  = 4;
   localparam int TIMEOUT_CYC = 1024;
   localparam int SETTLE_CYC  = 256;

   logic pclk = 1'b0;
   logic rst = 1'b1;
   logic cfg_valid = 1'b0;
   OP_t  cfg_op = '0;
   logic cfg_ready, cfg_err;
   logic core_idle = 1'b0;
   logic sclk = 1'b0;
   OP_t  op_out;
   logic div_rst_, xfer_en, locked, fault;

   int n_chk = 0;
   int n_err = 0;

   OP_t op_a, op_b, op_c, op_d, op_bad1, op_bad2;

   clk_cfg_ctrl #(
      .HOLD_CYC(HOLD_CYC), .LOCK_EDGES(LOCK_EDGES),
      .TIMEOUT_CYC(TIMEOUT_CYC), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .pclk(pclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_op(cfg_op),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .core_idle(core_idle),
      .sclk(sclk), .op_out(op_out), .div_rst_(div_rst_), .xfer_en(xfer_en),
      .locked(locked), .fault(fault)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic offer(input OP_t op);
      $display("offer op=%h legal=%0d t=%0t", op, op_legal(op), $time);
      cfg_op    = op;
      cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tg);
      chk({tg, "_op"},    32'(op_out), 32'h0);
      chk({tg, "_drst"},  32'(div_rst_), 32'h0);
      chk({tg, "_xfer"},  32'(xfer_en), 32'h0);
      chk({tg, "_lock"},  32'(locked), 32'h0);
      chk({tg, "_fault"}, 32'(fault), 32'h0);
      chk({tg, "_err"},   32'(cfg_err), 32'h0);
      chk({tg, "_rdy"},   32'(cfg_ready), 32'h1);
   endtask

   // Entered one cycle into DRAIN with core_idle already high; walks HOLD, SETTLE, lock.
   task automatic master_seq(input OP_t op, input string tg);
      chk({tg, "_drain_rdy"}, 32'(cfg_ready), 32'h0);
      chk({tg, "_drain_xfer"}, 32'(xfer_en), 32'h0);
      step(1);
      chk({tg, "_op_load"}, 32'(op_out), 32'(op));
      chk({tg, "_hold_first"}, 32'(div_rst_), 32'h0);
      step(HOLD_CYC - 1);
      chk({tg, "_hold_last"}, 32'(div_rst_), 32'h0);
      step(1);
      chk({tg, "_settle_drst"}, 32'(div_rst_), 32'h1);
      chk({tg, "_settle_lock"}, 32'(locked), 32'h0);
`ifdef CLK_CFG_LOCK_CHECK_EN
      for (int i = 0; i < LOCK_EDGES - 1; i++) begin
         sclk = 1'b1;
         step(1);
         sclk = 1'b0;
         step(1);
      end
      chk({tg, "_pre_lock"}, 32'(locked), 32'h0);
      sclk = 1'b1;
      step(1);
      sclk = 1'b0;
`else
      step(SETTLE_CYC - 1);
      chk({tg, "_pre_lock"}, 32'(locked), 32'h0);
      step(1);
`endif
      chk({tg, "_locked"}, 32'(locked), 32'h1);
      chk({tg, "_xfer"}, 32'(xfer_en), 32'h1);
      chk({tg, "_lk_drst"}, 32'(div_rst_), 32'h1);
      chk({tg, "_lk_rdy"}, 32'(cfg_ready), 32'h1);
   endtask

   initial begin
      op_a    = '{MT, k32, hz44, stereo, f32bits, 1'b0};
      op_b    = '{MR, k16, hz48, mono, f16bits, 1'b0};
      op_c    = '{SR, k48, hz96, stereo, f24bits, 1'b1};
      op_d    = '{MT, k32, hz48, stereo, f32bits, 1'b1};
      op_bad1 = '{MT, k8, hz44, stereo, f32bits, 1'b1};
      op_bad2 = '{MR, k48, hz48, mono, f16bits, 1'b0};

      step(3);
      chk_reset_vals("rst");
      rst = 1'b0;
      step(1);
      chk_reset_vals("idle");

      // first master configuration, core already idle
      core_idle = 1'b1;
      offer(op_a);
      chk("a_drain_op", 32'(op_out), 32'h0);
      master_seq(op_a, "a");

      // illegal OPs leave everything alone
      offer(op_bad1);
      chk("bad1_err", 32'(cfg_err), 32'h1);
      chk("bad1_op", 32'(op_out), 32'(op_a));
      chk("bad1_lock", 32'(locked), 32'h1);
      step(1);
      chk("bad1_err_pulse", 32'(cfg_err), 32'h0);
      chk("bad1_lock2", 32'(locked), 32'h1);
      offer(op_bad2);
      chk("bad2_err", 32'(cfg_err), 32'h1);
      chk("bad2_xfer", 32'(xfer_en), 32'h1);
      step(1);

      // reconfigure while LOCKED with the core busy for 20 cycles
      core_idle = 1'b0;
      offer(op_b);
      chk("b_xfer_off", 32'(xfer_en), 32'h0);
      chk("b_lock_off", 32'(locked), 32'h0);
      chk("b_op_hold", 32'(op_out), 32'(op_a));
      step(19);
      chk("b_op_still", 32'(op_out), 32'(op_a));
      chk("b_drain_rdy", 32'(cfg_ready), 32'h0);
      chk("b_drain_drst", 32'(div_rst_), 32'h0);
      core_idle = 1'b1;
      master_seq(op_b, "b");

      // slave OP skips HOLD/SETTLE and keeps divider in reset
      offer(op_c);
      chk("c_drain_lock", 32'(locked), 32'h0);
      step(1);
      chk("c_op", 32'(op_out), 32'(op_c));
      chk("c_locked", 32'(locked), 32'h1);
      chk("c_xfer", 32'(xfer_en), 32'h1);
      chk("c_drst", 32'(div_rst_), 32'h0);
      step(2);
      chk("c_drst_hold", 32'(div_rst_), 32'h0);

`ifdef CLK_CFG_LOCK_CHECK_EN
      // sclk stuck low: timeout into FAULT, then a legal OP relocks
      offer(op_a);
      step(1 + HOLD_CYC);
      chk("to_settle", 32'(div_rst_), 32'h1);
      step(TIMEOUT_CYC - 1);
      chk("to_pre_fault", 32'(fault), 32'h0);
      step(1);
      chk("to_fault", 32'(fault), 32'h1);
      chk("to_drst", 32'(div_rst_), 32'h0);
      chk("to_xfer", 32'(xfer_en), 32'h0);
      chk("to_rdy", 32'(cfg_ready), 32'h1);
      offer(op_d);
      chk("to_clear", 32'(fault), 32'h0);
      master_seq(op_d, "relock");
`endif

      // reset asserted during SETTLE
      offer(op_d);
      step(1 + HOLD_CYC);
      chk("rs_settle", 32'(div_rst_), 32'h1);
      rst = 1'b1;
      step(1);
      chk_reset_vals("rs");
      rst = 1'b0;
      step(1);
      chk("rs_idle_rdy", 32'(cfg_ready), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
